// File: rtl/plot_capture_pkg.sv
// Shared constants, FSM encoding and helpers for the plot capture block.
package plot_capture_pkg;

  localparam int DEF_WIDTH  = 80;
  localparam int DEF_HEIGHT = 110;

  localparam int COORD_W    = 7;
  localparam int COLOUR_W   = 3;
  localparam int MISMATCH_W = 14;
  localparam int DROP_W     = 8;

  localparam logic [COLOUR_W-1:0] BLACK = 3'b000;
  localparam logic [COLOUR_W-1:0] WHITE = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_t;

  function automatic logic [MISMATCH_W-1:0] sat_inc_mm(input logic [MISMATCH_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/plot_capture_if.sv
// Plot write strobe, scan control and scan readback/status signals.
interface plot_capture_if
  import plot_capture_pkg::*;
  ;
  logic [COORD_W-1:0]    in_x;
  logic [COORD_W-1:0]    in_y;
  logic [COLOUR_W-1:0]   in_colour;
  logic                  plot;
  logic                  scan_go;
  logic [COLOUR_W-1:0]   expect_colour;
  logic [COORD_W-1:0]    scan_x;
  logic [COORD_W-1:0]    scan_y;
  logic [COLOUR_W-1:0]   scan_colour;
  logic                  scan_valid;
  logic                  scan_done;
  logic                  all_match;
  logic [MISMATCH_W-1:0] mismatch_count;
  logic [DROP_W-1:0]     drop_count;
  logic                  busy;

  modport master (
    output in_x, in_y, in_colour, plot, scan_go, expect_colour,
    input  scan_x, scan_y, scan_colour, scan_valid, scan_done,
           all_match, mismatch_count, drop_count, busy
  );

  modport slave (
    input  in_x, in_y, in_colour, plot, scan_go, expect_colour,
    output scan_x, scan_y, scan_colour, scan_valid, scan_done,
           all_match, mismatch_count, drop_count, busy
  );
endinterface

// File: rtl/plot_capture_fb_ram_1w1r.sv
// Framebuffer: one synchronous write port, one registered read port (read-before-write).
module fb_ram_1w1r #(
  parameter int            DEPTH   = 8800,
  parameter int            AW      = 14,
  parameter int            DW      = 3,
  parameter logic [DW-1:0] RST_VAL = '0
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Storage is never reset; only the read register is.
  always_ff @(posedge clock) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset)   rdata <= RST_VAL;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/plot_capture.sv
// Captures pixel plots into a framebuffer and scans it back, comparing against a reference colour.
module plot_capture
  import plot_capture_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic           clock,
  input  logic           reset,
  plot_capture_if.slave  cap
);

  localparam int DEPTH = WIDTH * HEIGHT;
  localparam int AW    = $clog2(DEPTH);

  scan_state_t           state;
  logic [COORD_W-1:0]    rd_x, rd_y;
  logic [COORD_W-1:0]    sx_q, sy_q;
  logic [COLOUR_W-1:0]   exp_q;
  logic [COLOUR_W-1:0]   rd_colour;
  logic [MISMATCH_W-1:0] mm_q, mm_next;
  logic [DROP_W-1:0]     drop_q;
  logic                  valid_q, done_q, match_q, busy_q;
  logic                  in_range, we, re;
  logic [AW-1:0]         waddr, raddr;

  always_comb begin
    in_range = (int'(cap.in_x) < WIDTH) && (int'(cap.in_y) < HEIGHT);
    we       = cap.plot && in_range;
    waddr    = AW'(int'(cap.in_y) * WIDTH + int'(cap.in_x));
    raddr    = AW'(int'(rd_y) * WIDTH + int'(rd_x));
    re       = (state == SCAN);
    mm_next  = mm_q;
    if (valid_q && (rd_colour != exp_q)) mm_next = sat_inc_mm(mm_q);
  end

  fb_ram_1w1r #(
    .DEPTH   (DEPTH),
    .AW      (AW),
    .DW      (COLOUR_W),
    .RST_VAL (BLACK)
  ) u_fb (
    .clock (clock),
    .reset (reset),
    .we    (we),
    .waddr (waddr),
    .wdata (cap.in_colour),
    .re    (re),
    .raddr (raddr),
    .rdata (rd_colour)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      drop_q <= '0;
    end else if (cap.plot && !in_range && (drop_q != '1)) begin
      drop_q <= drop_q + 1'b1;
    end
  end

  // Readback lags the issued address by one cycle, so DONE still folds in the last pixel.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      rd_x    <= '0;
      rd_y    <= '0;
      sx_q    <= '0;
      sy_q    <= '0;
      exp_q   <= BLACK;
      mm_q    <= '0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
      match_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      done_q  <= 1'b0;
      valid_q <= (state == SCAN);
      if (state == SCAN) begin
        sx_q <= rd_x;
        sy_q <= rd_y;
      end
      case (state)
        IDLE: begin
          if (cap.scan_go) begin
            state  <= SCAN;
            exp_q  <= cap.expect_colour;
            rd_x   <= '0;
            rd_y   <= '0;
            mm_q   <= '0;
            busy_q <= 1'b1;
          end
        end
        SCAN: begin
          mm_q <= mm_next;
          if (rd_x == COORD_W'(WIDTH - 1)) begin
            rd_x <= '0;
            if (rd_y == COORD_W'(HEIGHT - 1)) state <= DONE;
            else                              rd_y  <= rd_y + 1'b1;
          end else begin
            rd_x <= rd_x + 1'b1;
          end
        end
        DONE: begin
          mm_q    <= mm_next;
          match_q <= (mm_next == '0);
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cap.scan_x         = sx_q;
  assign cap.scan_y         = sy_q;
  assign cap.scan_colour    = rd_colour;
  assign cap.scan_valid     = valid_q;
  assign cap.scan_done      = done_q;
  assign cap.all_match      = match_q;
  assign cap.mismatch_count = mm_q;
  assign cap.drop_count     = drop_q;
  assign cap.busy           = busy_q;

endmodule

// File: tb/tb_plot_capture.sv
// Directed bench for plot_capture: fills, scans, drops, same-cycle access, ignored starts, mid-scan reset.
module tb_plot_capture;
  import plot_capture_pkg::*;

  localparam int W    = 80;
  localparam int H    = 110;
  localparam int NPIX = W * H;

  logic clock = 1'b0;
  logic reset = 1'b1;

  plot_capture_if cap();

  plot_capture #(.WIDTH(W), .HEIGHT(H)) dut (
    .clock (clock),
    .reset (reset),
    .cap   (cap)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  // Observations gathered by run_scan.
  int         r_done_cyc, r_ndone, r_beats, r_order_err, r_nmis, r_busy_gap;
  logic [6:0] r_mis_x, r_mis_y;
  logic [2:0] r_mis_c, r_watch_c;

  task automatic plot_one(input logic [6:0] x, input logic [6:0] y, input logic [2:0] c);
    cap.plot = 1'b1; cap.in_x = x; cap.in_y = y; cap.in_colour = c;
    @(posedge clock); #1;
    cap.plot = 1'b0;
  endtask

  task automatic fill_all(input logic [2:0] c);
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        cap.plot = 1'b1; cap.in_x = 7'(x); cap.in_y = 7'(y); cap.in_colour = c;
        @(posedge clock); #1;
      end
    end
    cap.plot = 1'b0;
  endtask

  // Starts a scan and observes it; c counts edges after the edge that samples scan_go.
  task automatic run_scan(input logic [2:0] exp, input int watch_idx,
                          input int inj_cyc, input logic [6:0] inj_x, input logic [6:0] inj_y,
                          input logic [2:0] inj_c, input int go_mid, input bit go_in_done,
                          input int tail);
    int c;
    bit go_next;
    r_done_cyc = -1; r_ndone = 0; r_beats = 0; r_order_err = 0; r_nmis = 0; r_busy_gap = 0;
    r_mis_x = '0; r_mis_y = '0; r_mis_c = '0; r_watch_c = 3'bxxx;
    cap.expect_colour = exp;
    cap.scan_go = 1'b1;
    @(posedge clock); #1;
    cap.scan_go = 1'b0;
    c = 0;
    go_next = 1'b0;
    while (c < NPIX + 50) begin
      cap.plot = (c == inj_cyc);
      if (c == inj_cyc) begin
        cap.in_x = inj_x; cap.in_y = inj_y; cap.in_colour = inj_c;
      end
      cap.scan_go = (c == go_mid) || go_next;
      go_next = 1'b0;
      @(posedge clock); #1;
      c++;
      if (cap.scan_valid) begin
        if (cap.scan_x !== 7'(r_beats % W) || cap.scan_y !== 7'(r_beats / W)) r_order_err++;
        if (r_beats == watch_idx) r_watch_c = cap.scan_colour;
        if (cap.scan_colour !== exp) begin
          if (r_nmis == 0) begin
            r_mis_x = cap.scan_x; r_mis_y = cap.scan_y; r_mis_c = cap.scan_colour;
          end
          r_nmis++;
        end
        if (r_beats == NPIX - 1 && go_in_done) go_next = 1'b1;
        r_beats++;
      end
      if (c <= NPIX && cap.busy !== 1'b1) r_busy_gap++;
      if (cap.scan_done === 1'b1) begin
        r_ndone++;
        if (r_done_cyc < 0) r_done_cyc = c;
      end
      if (r_done_cyc >= 0 && c >= r_done_cyc + tail) break;
    end
    cap.plot = 1'b0;
    cap.scan_go = 1'b0;
  endtask

  task automatic test_reset();
    cap.plot = 1'b0; cap.scan_go = 1'b0; cap.in_x = '0; cap.in_y = '0;
    cap.in_colour = '0; cap.expect_colour = '0;
    reset = 1'b1;
    repeat (2) @(posedge clock);
    #1;
    total++; if (cap.busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%0d want=0", cap.busy); end
    total++; if (cap.scan_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%0d want=0", cap.scan_valid); end
    total++; if (cap.scan_done !== 1'b0) begin bad++; $display("FAIL rst_done got=%0d want=0", cap.scan_done); end
    total++; if (cap.all_match !== 1'b0) begin bad++; $display("FAIL rst_all_match got=%0d want=0", cap.all_match); end
    total++; if (cap.mismatch_count !== 14'd0) begin bad++; $display("FAIL rst_mismatch got=%0d want=0", cap.mismatch_count); end
    total++; if (cap.drop_count !== 8'd0) begin bad++; $display("FAIL rst_drop got=%0d want=0", cap.drop_count); end
    total++; if (cap.scan_x !== 7'd0) begin bad++; $display("FAIL rst_scan_x got=%0d want=0", cap.scan_x); end
    total++; if (cap.scan_y !== 7'd0) begin bad++; $display("FAIL rst_scan_y got=%0d want=0", cap.scan_y); end
    total++; if (cap.scan_colour !== 3'd0) begin bad++; $display("FAIL rst_scan_colour got=%0d want=0", cap.scan_colour); end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_fill_scan();
    fill_all(BLACK);
    run_scan(BLACK, -1, -1, 7'd0, 7'd0, 3'd0, -1, 1'b0, 3);
    total++; if (r_done_cyc !== NPIX + 1) begin bad++; $display("FAIL full_latency got=%0d want=%0d", r_done_cyc, NPIX + 1); end
    total++; if (r_ndone !== 1) begin bad++; $display("FAIL full_done_pulses got=%0d want=1", r_ndone); end
    total++; if (r_beats !== NPIX) begin bad++; $display("FAIL full_beats got=%0d want=%0d", r_beats, NPIX); end
    total++; if (r_order_err !== 0) begin bad++; $display("FAIL full_order got=%0d want=0", r_order_err); end
    total++; if (r_busy_gap !== 0) begin bad++; $display("FAIL full_busy_gap got=%0d want=0", r_busy_gap); end
    total++; if (r_nmis !== 0) begin bad++; $display("FAIL full_mis_beats got=%0d want=0", r_nmis); end
    total++; if (cap.mismatch_count !== 14'd0) begin bad++; $display("FAIL full_mismatch got=%0d want=0", cap.mismatch_count); end
    total++; if (cap.all_match !== 1'b1) begin bad++; $display("FAIL full_all_match got=%0d want=1", cap.all_match); end
    total++; if (cap.busy !== 1'b0) begin bad++; $display("FAIL full_busy_after got=%0d want=0", cap.busy); end
    repeat (5) @(posedge clock);
    #1;
    total++; if (cap.all_match !== 1'b1) begin bad++; $display("FAIL all_match_hold got=%0d want=1", cap.all_match); end
  endtask

  task automatic test_single_mismatch();
    plot_one(7'd5, 7'd7, WHITE);
    run_scan(BLACK, -1, -1, 7'd0, 7'd0, 3'd0, -1, 1'b0, 2);
    total++; if (r_nmis !== 1) begin bad++; $display("FAIL single_mis_beats got=%0d want=1", r_nmis); end
    total++; if (r_mis_x !== 7'd5) begin bad++; $display("FAIL single_mis_x got=%0d want=5", r_mis_x); end
    total++; if (r_mis_y !== 7'd7) begin bad++; $display("FAIL single_mis_y got=%0d want=7", r_mis_y); end
    total++; if (r_mis_c !== 3'd7) begin bad++; $display("FAIL single_mis_colour got=%0d want=7", r_mis_c); end
    total++; if (cap.mismatch_count !== 14'd1) begin bad++; $display("FAIL single_mismatch got=%0d want=1", cap.mismatch_count); end
    total++; if (cap.all_match !== 1'b0) begin bad++; $display("FAIL single_all_match got=%0d want=0", cap.all_match); end
    total++; if (r_done_cyc !== NPIX + 1) begin bad++; $display("FAIL single_latency got=%0d want=%0d", r_done_cyc, NPIX + 1); end
  endtask

  task automatic test_drops();
    plot_one(7'd80, 7'd0, WHITE);
    plot_one(7'd0, 7'd110, WHITE);
    plot_one(7'd127, 7'd127, WHITE);
    total++; if (cap.drop_count !== 8'd3) begin bad++; $display("FAIL drop_three got=%0d want=3", cap.drop_count); end
    cap.plot = 1'b1; cap.in_x = 7'd100; cap.in_y = 7'd0; cap.in_colour = WHITE;
    repeat (252) @(posedge clock);
    #1;
    total++; if (cap.drop_count !== 8'd255) begin bad++; $display("FAIL drop_reach_max got=%0d want=255", cap.drop_count); end
    repeat (45) @(posedge clock);
    #1;
    cap.plot = 1'b0;
    total++; if (cap.drop_count !== 8'd255) begin bad++; $display("FAIL drop_saturate got=%0d want=255", cap.drop_count); end
  endtask

  // Pixel 250 is (10,3); its address is issued on the 251st edge after the start edge.
  task automatic test_same_cycle();
    run_scan(BLACK, 250, 250, 7'd10, 7'd3, 3'd5, -1, 1'b0, 2);
    total++; if (r_watch_c !== 3'd0) begin bad++; $display("FAIL same_cycle_old got=%0d want=0", r_watch_c); end
    total++; if (r_nmis !== 1) begin bad++; $display("FAIL fb_unchanged_beats got=%0d want=1", r_nmis); end
    total++; if (cap.mismatch_count !== 14'd1) begin bad++; $display("FAIL same_cycle_mismatch got=%0d want=1", cap.mismatch_count); end
    run_scan(BLACK, 250, -1, 7'd0, 7'd0, 3'd0, -1, 1'b0, 2);
    total++; if (r_watch_c !== 3'd5) begin bad++; $display("FAIL same_cycle_new got=%0d want=5", r_watch_c); end
    total++; if (r_nmis !== 2) begin bad++; $display("FAIL rescan_mis_beats got=%0d want=2", r_nmis); end
    total++; if (cap.mismatch_count !== 14'd2) begin bad++; $display("FAIL rescan_mismatch got=%0d want=2", cap.mismatch_count); end
  endtask

  task automatic test_ignore_go();
    run_scan(BLACK, -1, -1, 7'd0, 7'd0, 3'd0, 100, 1'b1, 20);
    total++; if (r_ndone !== 1) begin bad++; $display("FAIL ignore_done_pulses got=%0d want=1", r_ndone); end
    total++; if (r_done_cyc !== NPIX + 1) begin bad++; $display("FAIL ignore_latency got=%0d want=%0d", r_done_cyc, NPIX + 1); end
    total++; if (r_beats !== NPIX) begin bad++; $display("FAIL ignore_beats got=%0d want=%0d", r_beats, NPIX); end
    total++; if (cap.busy !== 1'b0) begin bad++; $display("FAIL ignore_no_restart got=%0d want=0", cap.busy); end
    total++; if (cap.mismatch_count !== 14'd2) begin bad++; $display("FAIL ignore_mismatch got=%0d want=2", cap.mismatch_count); end
  endtask

  task automatic test_reset_mid_scan();
    int ndone;
    int nbusy;
    cap.expect_colour = WHITE;
    cap.scan_go = 1'b1;
    @(posedge clock); #1;
    cap.scan_go = 1'b0;
    repeat (500) @(posedge clock);
    #1;
    total++; if (cap.mismatch_count === 14'd0) begin bad++; $display("FAIL pre_reset_mismatch got=%0d want=nonzero", cap.mismatch_count); end
    #2;
    reset = 1'b1;
    #1;
    total++; if (cap.busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0d want=0", cap.busy); end
    total++; if (cap.scan_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0d want=0", cap.scan_valid); end
    total++; if (cap.mismatch_count !== 14'd0) begin bad++; $display("FAIL midrst_mismatch got=%0d want=0", cap.mismatch_count); end
    @(posedge clock); #1;
    reset = 1'b0;
    ndone = 0;
    nbusy = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clock); #1;
      if (cap.scan_done !== 1'b0) ndone++;
      if (cap.busy !== 1'b0) nbusy++;
    end
    total++; if (ndone !== 0) begin bad++; $display("FAIL midrst_no_done got=%0d want=0", ndone); end
    total++; if (nbusy !== 0) begin bad++; $display("FAIL midrst_stays_idle got=%0d want=0", nbusy); end
    total++; if (cap.all_match !== 1'b0) begin bad++; $display("FAIL midrst_all_match got=%0d want=0", cap.all_match); end
    run_scan(BLACK, 250, -1, 7'd0, 7'd0, 3'd0, -1, 1'b0, 2);
    total++; if (r_watch_c !== 3'd5) begin bad++; $display("FAIL fb_kept_10_3 got=%0d want=5", r_watch_c); end
    total++; if (cap.mismatch_count !== 14'd2) begin bad++; $display("FAIL fb_kept_mismatch got=%0d want=2", cap.mismatch_count); end
  endtask

  initial begin
    test_reset();
    test_fill_scan();
    test_single_mismatch();
    test_drops();
    test_same_cycle();
    test_ignore_go();
    test_reset_mid_scan();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
